// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with run/hold/done control FSM
// Optional build macro: COUNTDOWN_AUTO_RELOAD_EN (periodic reload instead of one-shot DONE).
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             tc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic             busy_q,   busy_d;
  logic             paused_q, paused_d;
  logic             done_q,   done_d;
  logic             tc_q,     tc_d;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Reload value only matters when the terminal edge wraps back into RUN.
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = data;
      state_d = IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = data;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count_q == '0) begin
              state_d = DONE;
              tc_d    = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (pause) begin
            state_d = HOLD;
          end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            tc_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = DONE;
`endif
          end
        end
        HOLD: begin
          if (stop) begin
            state_d = IDLE;
          end else if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
          if (stop || ack) begin
            state_d = IDLE;
          end
        end
      endcase
    end
    busy_d   = (state_d == RUN) || (state_d == HOLD);
    paused_d = (state_d == HOLD);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;
  assign tc     = tc_q;

endmodule
